// File: rtl/uart_rx.sv
// UART receiver. The serial line is synchronized, sampled at N_TICKS
// oversample ticks per bit, and decoded LSB first. Each frame ends with
// either a done pulse carrying the new byte or a frame-error pulse.
module uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int N_BITS    = 8,
    parameter int N_TICKS   = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx,
    output logic [N_BITS-1:0] o_dout,
    output logic              o_rx_done_tick,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * N_TICKS);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W   = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
    localparam int N_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_MID    = S_W'(N_TICKS / 2 - 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(N_TICKS - 1);
    localparam logic [N_W-1:0]   N_LAST   = N_W'(N_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [S_W-1:0]     s_q, s_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [N_BITS-1:0]  shreg_q, shreg_d;
    logic [N_BITS-1:0]  dout_q, dout_d;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;
    logic [DIV_W-1:0]   tick_cnt;
    logic               tick;
    logic               rx_meta;
    logic               rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running oversample tick generator, never stopped by the FSM.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == DIV_LAST);

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: start is checked at mid-bit, data and stop bits
    // one full bit period later each, so every sample lands mid-bit.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        shreg_d = {rx_s, shreg_q[N_BITS-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        if (rx_s) begin
                            state_d = IDLE;
                            dout_d  = shreg_q;
                            done_d  = 1'b1;
                        end else begin
                            state_d = WAIT_IDLE;
                            ferr_d  = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must return high before a new frame.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_dout         = dout_q;
    assign o_rx_done_tick = done_q;
    assign o_frame_err    = ferr_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, expected events queued by the
// driver and checked by an independent monitor.
module tb_uart_rx;

    localparam int BIT = 160;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] dout;
    logic       done;
    logic       ferr;
    logic       busy;

    int tests = 0;
    int fails = 0;

    // Expected events: bit 8 set = frame error, else done with data in [7:0].
    logic [8:0] exp_q[$];
    logic [7:0] prev_dout;

    uart_rx #(
        .CLK_FREQ (1600000),
        .BAUD_RATE(10000),
        .N_BITS   (8),
        .N_TICKS  (16)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_rx          (rx),
        .o_dout        (dout),
        .o_rx_done_tick(done),
        .o_frame_err   (ferr),
        .o_busy        (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int bit_len);
        rx = 1'b0;
        wait_clk(bit_len);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clk(bit_len);
        end
        rx = stop;
        wait_clk(bit_len);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dout = dout;
        end else begin
            if (done && ferr) begin
                tests++;
                fails++;
                $display("FAIL both_pulses: done=1 frame_err=1 required not both");
            end
            if (done || ferr) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: done=%0b frame_err=%0b dout=0x%0h, none expected",
                             done, ferr, dout);
                end else begin
                    check("event", {23'd0, ferr, (ferr ? 8'h00 : dout)}, {23'd0, exp_q.pop_front()});
                end
            end
            if (!done && dout !== prev_dout) begin
                tests++;
                fails++;
                $display("FAIL dout_hold: dout changed 0x%0h -> 0x%0h without done", prev_dout, dout);
            end
            prev_dout = dout;
        end
    end

    // Stimulus
    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        wait_clk(5);
        @(negedge clk);
        check("reset_dout", {24'd0, dout}, 32'h0);
        check("reset_done", {31'd0, done}, 32'h0);
        check("reset_ferr", {31'd0, ferr}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        @(posedge clk);
        rst_n = 1'b1;
        wait_clk(20);

        // Single frame
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, BIT);
        wait_clk(2 * BIT);
        @(negedge clk);
        check("a5_dout", {24'd0, dout}, 32'hA5);
        check("a5_busy", {31'd0, busy}, 32'h0);

        // Back-to-back frames
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h00, 1'b1, BIT);
        send_frame(8'hFF, 1'b1, BIT);
        send_frame(8'h3C, 1'b1, BIT);
        wait_clk(2 * BIT);
        @(negedge clk);
        check("b2b_busy", {31'd0, busy}, 32'h0);

        // Glitch shorter than half a bit
        @(posedge clk);
        rx = 1'b0;
        wait_clk(40);
        rx = 1'b1;
        wait_clk(2 * BIT);
        @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'h0);
        check("glitch_dout", {24'd0, dout}, 32'h3C);

        // Frame error followed by a held break, then a good frame
        @(posedge clk);
        exp_q.push_back({1'b1, 8'h00});
        send_frame(8'h55, 1'b0, BIT);
        wait_clk(3 * BIT);
        @(negedge clk);
        check("break_busy", {31'd0, busy}, 32'h1);
        check("break_dout", {24'd0, dout}, 32'h3C);
        @(posedge clk);
        rx = 1'b1;
        wait_clk(2 * BIT);
        @(negedge clk);
        check("break_end_busy", {31'd0, busy}, 32'h0);
        @(posedge clk);
        exp_q.push_back({1'b0, 8'h12});
        send_frame(8'h12, 1'b1, BIT);
        wait_clk(2 * BIT);

        // Reset during data bit 4 of 0x81
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0) ? 1'b1 : 1'b0;
            wait_clk(BIT);
        end
        rx = 1'b0;
        wait_clk(BIT / 2);
        rst_n = 1'b0;
        wait_clk(3);
        @(negedge clk);
        check("midrst_dout", {24'd0, dout}, 32'h0);
        check("midrst_done", {31'd0, done}, 32'h0);
        check("midrst_ferr", {31'd0, ferr}, 32'h0);
        check("midrst_busy", {31'd0, busy}, 32'h0);
        @(posedge clk);
        rx = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(2 * BIT);
        @(negedge clk);
        check("postrst_busy", {31'd0, busy}, 32'h0);
        @(posedge clk);
        exp_q.push_back({1'b0, 8'h7E});
        send_frame(8'h7E, 1'b1, BIT);
        wait_clk(2 * BIT);

        // Baud mismatch of about +3% and -3%
        exp_q.push_back({1'b0, 8'hC3});
        send_frame(8'hC3, 1'b1, BIT + 5);
        wait_clk(2 * BIT);
        exp_q.push_back({1'b0, 8'hC3});
        send_frame(8'hC3, 1'b1, BIT - 5);
        wait_clk(2 * BIT);
        @(negedge clk);
        check("skew_dout", {24'd0, dout}, 32'hC3);
        check("final_busy", {31'd0, busy}, 32'h0);

        wait_clk(100);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
